cpu6_intc: RTL and testbench

//  Parametrised machine-mode interrupt controller; generalises the single timer-IRQ path into NIRQ sources.

---
 rtl/cpu6_intc_if.sv | 30 +++
 rtl/cpu6_intc.sv | 124 ++++++++++++
 tb/tb_cpu6_intc.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu6_intc_if.sv
// Bus between the core and the machine-mode interrupt controller.
// The core side (master) drives the raw lines, enable writes and trap
// handshake. The controller side (slave) returns the request, its cause
// and the readable mip/mie views.
interface cpu6_intc_if #(
  parameter int NIRQ = 4,
  parameter int XLEN = 32
);
  logic [NIRQ-1:0] irq_i;
  logic            en_we;
  logic [NIRQ-1:0] en_wdata;
  logic            csr_mie;
  logic            irq_ack;
  logic            mret;
  logic            irq_req;
  logic [XLEN-1:0] irq_cause;
  logic            in_service;
  logic [NIRQ-1:0] pend_o;
  logic [NIRQ-1:0] en_o;

  modport master (
    output irq_i, en_we, en_wdata, csr_mie, irq_ack, mret,
    input  irq_req, irq_cause, in_service, pend_o, en_o
  );

  modport slave (
    input  irq_i, en_we, en_wdata, csr_mie, irq_ack, mret,
    output irq_req, irq_cause, in_service, pend_o, en_o
  );
endinterface

// File: rtl/cpu6_intc.sv
// Machine-mode interrupt controller for NIRQ sources.
// Each source latches pending state in edge or level mode. Pending state is
// masked by the per-source enables and the global MIE. A fixed-priority pick
// (index 0 highest) raises one request. The request is held until the core
// acks it, and then nothing new is raised until mret, so traps never nest.
module cpu6_intc #(
  parameter int              NIRQ       = 4,
  parameter int              XLEN       = 32,
  parameter logic [NIRQ-1:0] EDGE_MASK  = '0,
  parameter int              CAUSE_BASE = 16
) (
  input  logic         clk,
  input  logic         reset,
  cpu6_intc_if.slave   bus
);

  localparam int IDXW = (NIRQ > 1) ? $clog2(NIRQ) : 1;
  localparam logic [XLEN-1:0] CAUSE_MSB = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    INSVC = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [NIRQ-1:0] irq_q_reg;
  logic [NIRQ-1:0] pend_reg, pend_next;
  logic [NIRQ-1:0] en_reg;
  logic [NIRQ-1:0] clr;
  logic [NIRQ-1:0] elig;
  logic [IDXW-1:0] win_reg, win_next;
  logic [IDXW-1:0] winner;
  logic [XLEN-1:0] cause_reg, cause_next;

  assign elig = pend_reg & en_reg;

  // Per-source pending update. An edge source keeps its bit until the trap
  // for it is taken, but a fresh rise on that same edge re-arms it. A level
  // source simply follows its line, so clears do not apply to it.
  for (genvar gi = 0; gi < NIRQ; gi++) begin : g_src
    if (EDGE_MASK[gi]) begin : g_edge
      assign pend_next[gi] = (pend_reg[gi] & ~clr[gi])
                           | (bus.irq_i[gi] & ~irq_q_reg[gi]);
    end else begin : g_level
      assign pend_next[gi] = bus.irq_i[gi];
    end
  end

  // Fixed priority encoder: the lowest eligible index wins. The loop runs
  // downward so that the last match, which is the lowest index, is kept.
  always_comb begin
    winner = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        winner = IDXW'(i);
      end
    end
  end

  // Next state and cause. The cause is captured when the request is raised
  // and is held through servicing. clr pulses only on the ack edge.
  always_comb begin
    state_next = state_reg;
    win_next   = win_reg;
    cause_next = cause_reg;
    clr        = '0;
    case (state_reg)
      IDLE: begin
        if (bus.csr_mie && (|elig)) begin
          state_next = REQ;
          win_next   = winner;
          cause_next = CAUSE_MSB | (XLEN'(CAUSE_BASE) + XLEN'(winner));
        end
      end
      REQ: begin
        if (bus.irq_ack) begin
          state_next = INSVC;
          for (int i = 0; i < NIRQ; i++) begin
            clr[i] = (win_reg == IDXW'(i));
          end
        end
      end
      INSVC: begin
        if (bus.mret) begin
          state_next = IDLE;
          cause_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        cause_next = '0;
      end
    endcase
  end

  // State, capture flops and the enable register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      win_reg   <= '0;
      cause_reg <= '0;
      irq_q_reg <= '0;
      pend_reg  <= '0;
      en_reg    <= '0;
    end else begin
      state_reg <= state_next;
      win_reg   <= win_next;
      cause_reg <= cause_next;
      irq_q_reg <= bus.irq_i;
      pend_reg  <= pend_next;
      if (bus.en_we) begin
        en_reg <= bus.en_wdata;
      end
    end
  end

  assign bus.irq_req    = (state_reg == REQ);
  assign bus.in_service = (state_reg == INSVC);
  assign bus.irq_cause  = cause_reg;
  assign bus.pend_o     = pend_reg;
  assign bus.en_o       = en_reg;

endmodule

// File: tb/tb_cpu6_intc.sv
// Bench for cpu6_intc: directed scenarios with literal expectations, then a
// randomized phase. A behavioural model tracks the controller and a compare
// process checks every output on every cycle once the model has seen reset.
module tb_cpu6_intc;
  localparam int NIRQ = 4;
  localparam int XLEN = 32;
  localparam logic [NIRQ-1:0] EDGE_MASK = 4'b0001;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  cpu6_intc_if #(.NIRQ(NIRQ), .XLEN(XLEN)) bus ();

  cpu6_intc #(
    .NIRQ(NIRQ), .XLEN(XLEN), .EDGE_MASK(EDGE_MASK), .CAUSE_BASE(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) begin
        $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        m_valid = 0;
  bit [3:0]  m_pend, m_en, m_prev;
  bit        m_requesting, m_servicing;
  int        m_src;
  bit [31:0] m_cause;

  always @(posedge clk) begin
    bit [3:0] elig;
    bit [3:0] np;
    if (reset) begin
      m_valid = 1;
      m_pend = 0; m_en = 0; m_prev = 0;
      m_requesting = 0; m_servicing = 0; m_src = 0; m_cause = 0;
    end else begin
      elig = m_pend & m_en;
      for (int i = 0; i < NIRQ; i++) begin
        if (EDGE_MASK[i]) begin
          np[i] = (m_pend[i] && !(m_requesting && bus.irq_ack && m_src == i))
                  || (bus.irq_i[i] && !m_prev[i]);
        end else begin
          np[i] = bus.irq_i[i];
        end
      end
      if (m_requesting) begin
        if (bus.irq_ack) begin
          m_requesting = 0;
          m_servicing  = 1;
          $display("[TB] trap taken: src=%0d cause=%h", m_src, m_cause);
        end
      end else if (m_servicing) begin
        if (bus.mret) begin
          m_servicing = 0;
          m_cause     = 0;
        end
      end else if (bus.csr_mie && elig != 0) begin
        m_src = 0;
        while (!elig[m_src]) m_src++;
        m_requesting = 1;
        m_cause = 32'h8000_0000 + 32'd16 + 32'(m_src);
      end
      m_pend = np;
      if (bus.en_we) m_en = bus.en_wdata;
      m_prev = bus.irq_i;
    end
  end

  // Compare process: every cycle, on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_irq_req",    32'(bus.irq_req),    32'(m_requesting));
      chk("model_in_service", 32'(bus.in_service), 32'(m_servicing));
      chk("model_irq_cause",  bus.irq_cause,       m_cause);
      chk("model_pend",       32'(bus.pend_o),     32'(m_pend));
      chk("model_en",         32'(bus.en_o),       32'(m_en));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.irq_i = '0; bus.en_we = 0; bus.en_wdata = '0;
    bus.csr_mie = 0; bus.irq_ack = 0; bus.mret = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    step(); step();
    chk("rst_req",   32'(bus.irq_req), 0);
    chk("rst_cause", bus.irq_cause, 0);
    chk("rst_insvc", 32'(bus.in_service), 0);
    chk("rst_pend",  32'(bus.pend_o), 0);
    chk("rst_en",    32'(bus.en_o), 0);
    reset = 0;

    // 1: edge source 0 single pulse
    bus.en_we = 1; bus.en_wdata = 4'hF; bus.csr_mie = 1; step();
    bus.en_we = 0; bus.irq_i = 4'b0001; step();
    chk("s1_pend0", 32'(bus.pend_o[0]), 1);
    chk("s1_noreq_yet", 32'(bus.irq_req), 0);
    bus.irq_i = 4'b0000; step();
    chk("s1_req", 32'(bus.irq_req), 1);
    chk("s1_cause", bus.irq_cause, 32'h8000_0010);
    bus.irq_ack = 1; step();
    chk("s1_ack_req", 32'(bus.irq_req), 0);
    chk("s1_ack_insvc", 32'(bus.in_service), 1);
    chk("s1_ack_pend0", 32'(bus.pend_o[0]), 0);
    bus.irq_ack = 0; bus.mret = 1; step();
    chk("s1_mret_insvc", 32'(bus.in_service), 0);
    chk("s1_mret_cause", bus.irq_cause, 0);
    bus.mret = 0;

    // 2: priority between level sources 1 and 3
    bus.irq_i = 4'b1010; step(); step();
    chk("s2_cause1", bus.irq_cause, 32'h8000_0011);
    bus.irq_ack = 1; step();
    bus.irq_ack = 0; bus.irq_i = 4'b1000; bus.mret = 1; step();
    chk("s2_gap", 32'(bus.irq_req), 0);
    bus.mret = 0; step();
    chk("s2_req3", 32'(bus.irq_req), 1);
    chk("s2_cause3", bus.irq_cause, 32'h8000_0013);
    bus.irq_ack = 1; bus.irq_i = 4'b0000; step();
    bus.irq_ack = 0; bus.mret = 1; step();
    bus.mret = 0;

    // 5: edge source re-pulses on the ack edge
    bus.irq_i = 4'b0001; step();
    bus.irq_i = 4'b0000; step();
    chk("s5_req", 32'(bus.irq_req), 1);
    bus.irq_ack = 1; bus.irq_i = 4'b0001; step();
    chk("s5_pend0_kept", 32'(bus.pend_o[0]), 1);
    bus.irq_ack = 0; bus.irq_i = 4'b0000; bus.mret = 1; step();
    chk("s5_gap", 32'(bus.irq_req), 0);
    bus.mret = 0; step();
    chk("s5_req2", 32'(bus.irq_req), 1);
    chk("s5_cause2", bus.irq_cause, 32'h8000_0010);
    bus.irq_ack = 1; step();
    bus.irq_ack = 0; bus.mret = 1; step();
    bus.mret = 0;

    // 6: reset while in service with everything pending
    bus.irq_i = 4'hF; step(); step();
    bus.irq_ack = 1; step();
    bus.irq_ack = 0; bus.irq_i = 4'hE; step();
    bus.irq_i = 4'hF; step();
    chk("s6_pendF", 32'(bus.pend_o), 32'hF);
    chk("s6_insvc", 32'(bus.in_service), 1);
    reset = 1; step();
    chk("s6_req0",   32'(bus.irq_req), 0);
    chk("s6_insvc0", 32'(bus.in_service), 0);
    chk("s6_cause0", bus.irq_cause, 0);
    chk("s6_pend0",  32'(bus.pend_o), 0);
    chk("s6_en0",    32'(bus.en_o), 0);
    reset = 0; step(); step();
    chk("s6_no_req", 32'(bus.irq_req), 0);
    chk("s6_pend_after", 32'(bus.pend_o), 32'hF);

    // 3: masking by enable and by MIE
    bus.irq_i = 4'b0100; step(); step();
    chk("s3_en_masked", 32'(bus.irq_req), 0);
    bus.csr_mie = 0; bus.en_we = 1; bus.en_wdata = 4'b0100; step();
    bus.en_we = 0; step(); step();
    chk("s3_mie_masked", 32'(bus.irq_req), 0);
    bus.csr_mie = 1; step();
    chk("s3_req", 32'(bus.irq_req), 1);
    chk("s3_cause", bus.irq_cause, 32'h8000_0012);

    // 4: request held while line, MIE and enables change; stray mret
    bus.irq_i = 4'b0000; bus.csr_mie = 0; bus.en_we = 1; bus.en_wdata = 4'b0000;
    bus.mret = 1; step();
    bus.en_we = 0; bus.mret = 0; step();
    chk("s4_hold_req", 32'(bus.irq_req), 1);
    chk("s4_hold_cause", bus.irq_cause, 32'h8000_0012);
    bus.irq_ack = 1; step();
    bus.irq_ack = 0; bus.mret = 1; step();
    bus.mret = 0; bus.irq_ack = 1; step();
    chk("s4_stray_ack_req", 32'(bus.irq_req), 0);
    chk("s4_stray_ack_insvc", 32'(bus.in_service), 0);
    bus.irq_ack = 0;

    // Randomized phase
    bus.en_we = 1; bus.en_wdata = 4'hF; bus.csr_mie = 1; step();
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] nxt;
      nxt = bus.irq_i;
      for (int i = 1; i < NIRQ; i++) begin
        if ($urandom_range(0, 7) == 0) nxt[i] = ~nxt[i];
      end
      nxt[0] = ($urandom_range(0, 5) == 0);
      bus.irq_i    = nxt;
      bus.en_we    = ($urandom_range(0, 15) == 0);
      bus.en_wdata = 4'($urandom);
      bus.csr_mie  = ($urandom_range(0, 7) != 0);
      bus.irq_ack  = ($urandom_range(0, 2) == 0);
      bus.mret     = ($urandom_range(0, 2) == 0);
      reset        = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 0;
    idle_inputs();
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
